mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one 16-bit single-port data memory (memory2c) between instruction fetch (read-only) and the
//  memory stage (read/write). Arbitrates, holds address/data stable for a configurable number of wait
//  cycles, returns read data with a valid pulse, stalls the losing/waiting requester, and drops fetch
//  responses on pipeline flush. Sits between fetch, memory stage and the memory macro.
// PARAMETERS
//  ADDR_W       16  address width (memory2c uses [15:0])
//  DATA_W       16  data width
//  WAIT_CYCLES  0   extra cycles an access is held on the memory port (0 = single-cycle access)
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst        in   1       synchronous, active-low reset (rst==0 at a rising edge resets)
//  if_req     in   1       fetch read request; held until if_valid
//  if_addr    in   ADDR_W  fetch address
//  if_rdata   out  DATA_W  fetch read data, valid with if_valid, held until next fetch completion
//  if_valid   out  1       one-cycle pulse: fetch access done
//  if_stall   out  1       if_req && !if_valid
//  dm_req     in   1       data request; held until dm_valid
//  dm_wr      in   1       1 = write, 0 = read
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  write data
//  dm_rdata   out  DATA_W  data read data, valid with dm_valid (reads only)
//  dm_valid   out  1       one-cycle pulse: data access done (reads and writes)
//  dm_stall   out  1       dm_req && !dm_valid
//  flush      in   1       cancel fetch: pending/in-flight fetch gives no if_valid
//  mem_addr   out  ADDR_W  to memory2c addr
//  mem_wdata  out  DATA_W  to memory2c data_in
//  mem_wr     out  1       to memory2c wr; high only during a granted data write
//  mem_rdata  in   DATA_W  from memory2c data_out (combinational read)
// BEHAVIOUR
//  - Reset: state IDLE; if_valid, dm_valid, mem_wr = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0;
//    counter = 0; RR pointer (if enabled) = fetch-last. Reset mid-access aborts; mem_wr low next cycle.
//  - FSM IDLE -> ACCESS -> IDLE. IDLE: sample requests; grant one, latch addr/wdata/wr/owner,
//    load counter = WAIT_CYCLES, go ACCESS. No request: stay IDLE, mem_wr = 0.
//  - ACCESS: mem_* driven from latched regs (stable whole access). Counter decrements each cycle; at
//    counter==0 capture mem_rdata into owner's rdata reg (reads only), pulse owner valid next cycle.
//  - Latency: request sampled at edge T -> valid high in cycle T+2+WAIT_CYCLES. Back-to-back: the
//    cycle valid is high the FSM is IDLE and may grant again (sampled req must be new/next request).
//  - Requester deasserting req mid-access: access still completes, valid still pulses (no abort).
//  - Simultaneous if_req and dm_req: dm wins (fixed priority) unless MEM_ARB_RR_EN.
//  - flush with fetch in ACCESS: memory access completes, if_valid suppressed, if_rdata unchanged.
//    flush in IDLE: if_req ignored that cycle (no fetch grant); dm_req unaffected.
//  - Writes never pulse rdata update; dm_rdata keeps last read value.
//  - Counter width max(1,$clog2(WAIT_CYCLES+1)); no wrap (loaded, counts to 0, stops).
// CONFIGURATION
//  MEM_ARB_RR_EN defined: on simultaneous requests grant the port NOT granted last (1-bit pointer,
//    updated on every grant). Undefined: fixed dm-over-if priority; pointer logic absent.
// STRUCTURE
//  Package mem_arb_pkg: state enum {IDLE, ACCESS}, owner enum {OWN_IF, OWN_DM}, ADDR_W/DATA_W defaults.
//  One sub-module: mem_arb_wait_ctr (load/decrement/zero-flag counter, WAIT_CYCLES param).
// TESTING
//  1 WAIT_CYCLES=0, if_req addr 0x0010, mem holds 0xBEEF -> if_valid 2 cycles later, if_rdata=0xBEEF.
//  2 dm write 0x0020<=0x1234 then dm read 0x0020 -> mem_wr high 1 cycle only, dm_rdata=0x1234.
//  3 if_req+dm_req same cycle -> dm served first, if_stall high until if_valid after dm_valid;
//    with MEM_ARB_RR_EN and last=dm, fetch served first.
//  4 WAIT_CYCLES=3, dm read -> mem_addr stable 4 cycles, dm_valid in cycle T+5.
//  5 flush during fetch ACCESS -> no if_valid, if_rdata unchanged, next fetch normal.
//  6 rst low during dm write ACCESS -> next cycle IDLE, mem_wr=0, all valids 0, outputs 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Purpose : Shared types and defaults for the fetch/data memory arbiter.
//           - state_e : arbiter FSM states (IDLE, ACCESS)
//           - owner_e : which requester owns the current access
//           - ADDR_W_DEF / DATA_W_DEF : default bus widths (memory2c is 16/16)
//           - ctr_width() : wait counter width, max(1, clog2(WAIT_CYCLES+1))
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // A zero wait count still needs one bit so the counter port is never empty.
    function automatic int ctr_width(input int wait_cycles);
        if (wait_cycles < 1) begin
            return 1;
        end
        return $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// -----------------------------------------------------------------------------
// mem_arb_wait_ctr
// Purpose : Access hold counter. Loaded with WAIT_CYCLES when an access is
//           granted, decremented once per access cycle, saturates at zero.
// Ports   :
//   clk   in  clock
//   rst   in  synchronous active-low reset
//   load  in  load WAIT_CYCLES (takes priority over dec)
//   dec   in  decrement by one while non-zero
//   zero  out counter currently equals zero
// -----------------------------------------------------------------------------
module mem_arb_wait_ctr
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = ctr_width(WAIT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(WAIT_CYCLES);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Purpose : Shares one single-port data memory (memory2c) between instruction
//           fetch (read-only) and the memory stage (read/write). One access at a
//           time: IDLE grants a requester, ACCESS holds address/data on the
//           memory port for WAIT_CYCLES+1 cycles, then the owner's valid pulses
//           for one cycle with registered read data.
// Config  : MEM_ARB_RR_EN - when defined, simultaneous requests go to the port
//           that was not granted last; otherwise the data port always wins.
// Ports   :
//   clk, rst                          clock, synchronous active-low reset
//   if_req, if_addr                   fetch read request (held until if_valid)
//   if_rdata, if_valid, if_stall      fetch response / stall
//   dm_req, dm_wr, dm_addr, dm_wdata  data request (held until dm_valid)
//   dm_rdata, dm_valid, dm_stall      data response / stall
//   flush                             cancel pending or in-flight fetch
//   mem_addr, mem_wdata, mem_wr       to memory2c
//   mem_rdata                         from memory2c (combinational read)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q,    state_d;
    owner_e            owner_q,    owner_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              wr_q,       wr_d;
    logic              cancel_q,   cancel_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
`ifdef MEM_ARB_RR_EN
    owner_e            last_q,     last_d;
`endif

    logic ctr_load;
    logic ctr_dec;
    logic ctr_zero;

    logic if_cand;
    logic grant_dm;
    logic grant_if;

    mem_arb_wait_ctr #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (ctr_load),
        .dec  (ctr_dec),
        .zero (ctr_zero)
    );

    // A flush in the same cycle hides the fetch request from arbitration.
    always_comb begin
        if_cand = if_req && !flush;
`ifdef MEM_ARB_RR_EN
        if (if_cand && dm_req) begin
            grant_dm = (last_q == OWN_IF);
        end else begin
            grant_dm = dm_req;
        end
`else
        grant_dm = dm_req;
`endif
        grant_if = if_cand && !grant_dm;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        cancel_d   = cancel_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d     = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (grant_dm || grant_if) begin
                    state_d  = ACCESS;
                    owner_d  = grant_dm ? OWN_DM : OWN_IF;
                    addr_d   = grant_dm ? dm_addr : if_addr;
                    wr_d     = grant_dm && dm_wr;
                    cancel_d = 1'b0;
                    ctr_load = 1'b1;
                    if (grant_dm && dm_wr) begin
                        wdata_d = dm_wdata;
                    end
`ifdef MEM_ARB_RR_EN
                    last_d   = grant_dm ? OWN_DM : OWN_IF;
`endif
                end
            end

            ACCESS: begin
                ctr_dec = 1'b1;
                // Remember a flush seen at any point of a fetch access.
                if (flush && (owner_q == OWN_IF)) begin
                    cancel_d = 1'b1;
                end
                if (ctr_zero) begin
                    state_d = IDLE;
                    wr_d    = 1'b0;
                    if (owner_q == OWN_DM) begin
                        dm_valid_d = 1'b1;
                        if (!wr_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else if (!(cancel_q || flush)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            cancel_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q     <= OWN_IF;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            cancel_q   <= cancel_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wr    = wr_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign if_stall  = if_req && !if_valid_q;
    assign dm_stall  = dm_req && !dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiter instances: u_dut0 (WAIT_CYCLES=0) with a behavioural memory2c
// model, and u_dut3 (WAIT_CYCLES=3) with a read-only pattern memory
// (data = addr ^ 0xA5A5). Expected responses are queued when requests are
// driven and popped by a monitor when a valid pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic        is_dm;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        is_dm;
        logic [15:0] rdata;
    } sb_t;

    logic clk = 1'b0;
    logic rst;

    // u_dut0 signals
    logic        if_req, dm_req, dm_wr, flush;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, if_stall, dm_valid, dm_stall, mem_wr;

    // u_dut3 signals
    logic        w3_if_req, w3_dm_req, w3_dm_wr, w3_flush;
    logic [15:0] w3_if_addr, w3_dm_addr, w3_dm_wdata;
    logic [15:0] w3_if_rdata, w3_dm_rdata, w3_mem_addr, w3_mem_wdata, w3_mem_rdata;
    logic        w3_if_valid, w3_if_stall, w3_dm_valid, w3_dm_stall, w3_mem_wr;

    logic [15:0] mem_model [0:65535];

    sb_t  sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .flush(flush),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(w3_if_req), .if_addr(w3_if_addr), .if_rdata(w3_if_rdata),
        .if_valid(w3_if_valid), .if_stall(w3_if_stall),
        .dm_req(w3_dm_req), .dm_wr(w3_dm_wr), .dm_addr(w3_dm_addr), .dm_wdata(w3_dm_wdata),
        .dm_rdata(w3_dm_rdata), .dm_valid(w3_dm_valid), .dm_stall(w3_dm_stall),
        .flush(w3_flush),
        .mem_addr(w3_mem_addr), .mem_wdata(w3_mem_wdata), .mem_wr(w3_mem_wr),
        .mem_rdata(w3_mem_rdata)
    );

    // memory2c model: combinational read, write on rising edge; preloaded in reset
    assign mem_rdata    = mem_model[mem_addr];
    assign w3_mem_rdata = w3_mem_addr ^ 16'hA5A5;

    always @(posedge clk) begin
        if (!rst) begin
            mem_model[16'h0010] <= 16'hBEEF;
            mem_model[16'h0030] <= 16'hCAFE;
            mem_model[16'h0050] <= 16'h0F0F;
            mem_model[16'h0060] <= 16'h1111;
            mem_model[16'hFFFF] <= 16'h7E57;
        end else if (mem_wr) begin
            mem_model[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_pop(input logic is_dm, input logic [15:0] rd);
        sb_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid port=%s rdata=0x%0h required=no_valid",
                     is_dm ? "dm" : "if", rd);
        end else begin
            e = sb_q.pop_front();
            chk("sb_owner_is_dm", {31'd0, is_dm}, {31'd0, e.is_dm});
            chk(is_dm ? "sb_dm_rdata" : "sb_if_rdata", {16'd0, rd}, {16'd0, e.rdata});
            $display("txn port=%s rdata=0x%04h expected=0x%04h", is_dm ? "dm" : "if", rd, e.rdata);
        end
    endtask

    // Scoreboard monitor for u_dut0
    always @(negedge clk) begin
        if (dm_valid) mon_pop(1'b1, dm_rdata);
        if (if_valid) mon_pop(1'b0, if_rdata);
    end

    // Counts negedges from now until the port's valid is seen; also counts
    // cycles with mem_wr high before that point.
    task automatic wait_valid(input logic is_dm, output int lat, output int wr_cyc);
        bit done;
        done   = 1'b0;
        lat    = 0;
        wr_cyc = 0;
        while (!done) begin
            @(negedge clk);
            lat++;
            if (is_dm ? dm_valid : if_valid) begin
                done = 1'b1;
            end else begin
                if (mem_wr) wr_cyc++;
                if (lat >= 20) begin
                    checks++;
                    failures++;
                    $display("FAIL timeout_%s_valid waited=%0d required=valid", is_dm ? "dm" : "if", lat);
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation_time_exceeded required=finish");
        $fatal(1, "watchdog");
    end

    vec_t        vecs [8];
    sb_t         e;
    int          lat, wrc, saw, stable;
    logic [15:0] last_dm_rd, last_if_rd;
    logic        first_dm;

    initial begin
        rst = 1'b0;
        if_req = 0; if_addr = 0; dm_req = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0; flush = 0;
        w3_if_req = 0; w3_if_addr = 0; w3_dm_req = 0; w3_dm_wr = 0;
        w3_dm_addr = 0; w3_dm_wdata = 0; w3_flush = 0;
        last_dm_rd = 16'h0000;
        last_if_rd = 16'h0000;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 1'b0, 16'h0030, 16'h0000, 16'hCAFE};
        vecs[4] = '{1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0F0F};
        vecs[5] = '{1'b1, 1'b1, 16'h0050, 16'h5A5A, 16'h0000};
        vecs[6] = '{1'b0, 1'b0, 16'h0050, 16'h0000, 16'h5A5A};
        vecs[7] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h7E57};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_if_valid",  {31'd0, if_valid}, 0);
        chk("rst_dm_valid",  {31'd0, dm_valid}, 0);
        chk("rst_mem_wr",    {31'd0, mem_wr}, 0);
        chk("rst_mem_addr",  {16'd0, mem_addr}, 0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 0);
        chk("rst_if_rdata",  {16'd0, if_rdata}, 0);
        chk("rst_dm_rdata",  {16'd0, dm_rdata}, 0);
        chk("rst_w3_mem_addr", {16'd0, w3_mem_addr}, 0);
        rst = 1'b1;
        @(negedge clk);

        // ---- table-driven single accesses, back-to-back ----
        for (int i = 0; i < 8; i++) begin
            if_req   = !vecs[i].is_dm;
            if_addr  = vecs[i].addr;
            dm_req   = vecs[i].is_dm;
            dm_wr    = vecs[i].wr;
            dm_addr  = vecs[i].addr;
            dm_wdata = vecs[i].wdata;
            e.is_dm  = vecs[i].is_dm;
            if (vecs[i].is_dm && vecs[i].wr) begin
                e.rdata = last_dm_rd;
            end else begin
                e.rdata = vecs[i].exp_rdata;
                if (vecs[i].is_dm) last_dm_rd = vecs[i].exp_rdata;
                else               last_if_rd = vecs[i].exp_rdata;
            end
            sb_q.push_back(e);
            wait_valid(vecs[i].is_dm, lat, wrc);
            chk($sformatf("v%0d_latency", i), lat, 2);
            chk($sformatf("v%0d_mem_wr_cycles", i), wrc, vecs[i].wr ? 1 : 0);
        end
        if_req = 0; dm_req = 0; dm_wr = 0;
        @(negedge clk);

        // ---- simultaneous requests ----
`ifdef MEM_ARB_RR_EN
        first_dm = 1'b0;
`else
        first_dm = 1'b1;
`endif
        if_req = 1; if_addr = 16'h0010;
        dm_req = 1; dm_wr = 0; dm_addr = 16'h0030;
        if (first_dm) begin
            sb_q.push_back('{1'b1, 16'hCAFE});
            sb_q.push_back('{1'b0, 16'hBEEF});
        end else begin
            sb_q.push_back('{1'b0, 16'hBEEF});
            sb_q.push_back('{1'b1, 16'hCAFE});
        end
        last_dm_rd = 16'hCAFE;
        last_if_rd = 16'hBEEF;
        wait_valid(first_dm, lat, wrc);
        chk("sim_first_latency", lat, 2);
        chk("sim_loser_stall", {31'd0, first_dm ? if_stall : dm_stall}, 1);
        if (first_dm) dm_req = 0; else if_req = 0;
        wait_valid(!first_dm, lat, wrc);
        chk("sim_second_latency", lat, 2);
        if_req = 0; dm_req = 0;
        @(negedge clk);

        // ---- flush during fetch ACCESS ----
        saw = 0;
        if_req = 1; if_addr = 16'h0030;
        @(negedge clk);
        if (if_valid) saw++;
        flush = 1; if_req = 0;
        @(negedge clk);
        if (if_valid) saw++;
        flush = 0;
        repeat (3) begin
            @(negedge clk);
            if (if_valid) saw++;
        end
        chk("flush_if_valid_count", saw, 0);
        chk("flush_if_rdata_held", {16'd0, if_rdata}, {16'd0, last_if_rd});

        // ---- flush in IDLE blocks the grant; next fetch is normal ----
        if_req = 1; if_addr = 16'h0060; flush = 1;
        @(negedge clk);
        chk("flush_idle_no_grant", {31'd0, mem_addr == 16'h0060}, 0);
        flush = 0;
        sb_q.push_back('{1'b0, 16'h1111});
        last_if_rd = 16'h1111;
        wait_valid(1'b0, lat, wrc);
        chk("post_flush_fetch_latency", lat, 2);
        if_req = 0;
        @(negedge clk);

        // ---- WAIT_CYCLES=3 data read ----
        w3_dm_req = 1; w3_dm_wr = 0; w3_dm_addr = 16'h0123;
        lat = 0; stable = 0; saw = 0;
        while (saw == 0) begin
            @(negedge clk);
            lat++;
            if (w3_dm_valid) begin
                saw = 1;
            end else begin
                if (w3_mem_addr == 16'h0123) stable++;
                if (lat >= 20) begin
                    checks++;
                    failures++;
                    $display("FAIL timeout_w3_dm_valid waited=%0d required=valid", lat);
                    saw = 1;
                end
            end
        end
        $display("txn port=w3_dm rdata=0x%04h latency=%0d", w3_dm_rdata, lat);
        chk("w3_latency", lat, 5);
        chk("w3_mem_addr_stable_cycles", stable, 4);
        chk("w3_dm_rdata", {16'd0, w3_dm_rdata}, {16'd0, 16'h0123 ^ 16'hA5A5});
        w3_dm_req = 0;
        @(negedge clk);
        chk("w3_valid_single_pulse", {31'd0, w3_dm_valid}, 0);

        // ---- reset during a WAIT_CYCLES=3 write ----
        w3_dm_req = 1; w3_dm_wr = 1; w3_dm_addr = 16'h0040; w3_dm_wdata = 16'h9999;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_pre_mem_wr", {31'd0, w3_mem_wr}, 1);
        rst = 1'b0; w3_dm_req = 0; w3_dm_wr = 0;
        @(negedge clk);
        chk("rst_mid_mem_wr",    {31'd0, w3_mem_wr}, 0);
        chk("rst_mid_dm_valid",  {31'd0, w3_dm_valid}, 0);
        chk("rst_mid_mem_addr",  {16'd0, w3_mem_addr}, 0);
        chk("rst_mid_mem_wdata", {16'd0, w3_mem_wdata}, 0);
        chk("rst_mid_dm_rdata",  {16'd0, w3_dm_rdata}, 0);
        chk("rst_mid_if_rdata0", {16'd0, if_rdata}, 0);
        rst = 1'b1;
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            if (w3_dm_valid || w3_mem_wr) saw++;
        end
        chk("rst_mid_no_resume", saw, 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
